// File: rtl/rst_seq_pkg.sv
// Shared CSR constants and FSM encoding for the reset sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rst_seq_pkg;

  // Register offsets relative to the block base address.
  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_DELAY  = 2'd1;
  localparam logic [1:0] CSR_FORCE  = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;
  localparam logic [4:0] CSR_SPAN   = 5'd4;

  // CTRL write bits.
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rst_seq_if.sv
// CSR bus plus sequencer control/status signals bundled as one port.
// Latency: n/a (wiring only).
// Backpressure: none; CSR accesses always complete in one cycle.
// master: drives csr_a/csr_di/csr_we/start/ce, receives csr_do/out/busy/done.
// slave : the sequencer side.
interface rst_seq_if #(
  parameter int NUM_RESETS = 3
);
  logic [4:0]            csr_a;
  logic [7:0]            csr_di;
  logic                  csr_we;
  logic [7:0]            csr_do;
  logic                  start;
  logic                  ce;
  logic [NUM_RESETS-1:0] out;
  logic                  busy;
  logic                  done;

  modport master (
    output csr_a, csr_di, csr_we, start, ce,
    input  csr_do, out, busy, done
  );

  modport slave (
    input  csr_a, csr_di, csr_we, start, ce,
    output csr_do, out, busy, done
  );
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: holds NUM_RESETS lines in reset and releases them in index order.
// Latency: CSR writes/START act on the next edge; CSR reads are combinational.
// Backpressure: none; START while a sequence runs is dropped, ABORT always wins.
// Ports: clk, rst (sync, active-high); bus = CSR access, start pulse, ce tick,
//        out (1 = line held in reset), busy, done (one-cycle at last release).
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR  = 5'h0,
  parameter int         NUM_RESETS = 3,
  parameter logic [7:0] DFL_DELAY  = 8'd10
) (
  input  logic      clk,
  input  logic      rst,
  rst_seq_if.slave  bus
);

  localparam logic [2:0]            LAST_IDX = 3'(NUM_RESETS - 1);
  localparam logic [NUM_RESETS-1:0] ONE_BIT  = NUM_RESETS'(1);

  state_t                r_state;
  logic [NUM_RESETS-1:0] r_released;
  logic [2:0]            r_idx;
  logic [7:0]            r_cnt;
  logic [7:0]            r_delay;
  logic [NUM_RESETS-1:0] r_force;
  logic                  r_done;
  logic                  r_sticky;

  state_t                w_state_nxt;
  logic [NUM_RESETS-1:0] w_released_nxt;
  logic [2:0]            w_idx_nxt;
  logic [7:0]            w_cnt_nxt;
  logic                  w_done_nxt;
  logic                  w_sticky_nxt;

  // Address decode: subtracting the base lets an unsigned compare cover the
  // whole window, including addresses below the base (they wrap high).
  logic [4:0] w_off;
  logic       w_in_blk;
  logic       w_wr;
  logic       w_wr_ctrl;
  logic       w_start;
  logic       w_abort;

  assign w_off     = bus.csr_a - BASE_ADDR;
  assign w_in_blk  = (w_off < CSR_SPAN);
  assign w_wr      = bus.csr_we & w_in_blk;
  assign w_wr_ctrl = w_wr & (w_off[1:0] == CSR_CTRL);
  assign w_start   = bus.start | (w_wr_ctrl & bus.csr_di[CTRL_START_BIT]);
  assign w_abort   = w_wr_ctrl & bus.csr_di[CTRL_ABORT_BIT];

  // Next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_released_nxt = r_released;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = 1'b0;
    w_sticky_nxt   = r_sticky;

    if (w_abort) begin
      // ABORT beats a START carried in the same CTRL write.
      w_state_nxt    = ST_IDLE;
      w_released_nxt = '0;
      w_sticky_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            w_state_nxt    = ST_WAIT;
            w_released_nxt = '0;
            w_idx_nxt      = 3'd0;
            w_cnt_nxt      = r_delay;
            w_sticky_nxt   = 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.ce) begin
            if (r_cnt == 8'd0) begin
              w_released_nxt = r_released | (ONE_BIT << r_idx);
              // Reload from the live DELAY register so a mid-sequence
              // write only affects the gaps that follow.
              w_cnt_nxt      = r_delay;
              if (r_idx == LAST_IDX) begin
                w_state_nxt  = ST_DONE;
                w_done_nxt   = 1'b1;
                w_sticky_nxt = 1'b1;
              end else begin
                w_idx_nxt    = r_idx + 3'd1;
              end
            end else begin
              w_cnt_nxt = r_cnt - 8'd1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_released <= '0;
      r_idx      <= 3'd0;
      r_cnt      <= 8'd0;
      r_delay    <= DFL_DELAY;
      r_force    <= '0;
      r_done     <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_released <= w_released_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_sticky   <= w_sticky_nxt;
      if (w_wr && (w_off[1:0] == CSR_DELAY)) begin
        r_delay <= bus.csr_di;
      end
      if (w_wr && (w_off[1:0] == CSR_FORCE)) begin
        r_force <= bus.csr_di[NUM_RESETS-1:0];
      end
    end
  end

  // CSR read mux; narrow fields are zero-extended to the byte.
  logic [7:0] w_rd_dat;
  logic [7:0] w_force_rd;
  logic [7:0] w_rel_rd;

  always_comb begin
    w_force_rd                   = 8'h00;
    w_force_rd[NUM_RESETS-1:0]   = r_force;
    w_rel_rd                     = 8'h00;
    w_rel_rd[NUM_RESETS-1:0]     = r_released;
    w_rd_dat                     = 8'h00;
    if (w_in_blk) begin
      case (w_off[1:0])
        CSR_CTRL:   w_rd_dat = {6'b0, r_sticky, (r_state == ST_WAIT)};
        CSR_DELAY:  w_rd_dat = r_delay;
        CSR_FORCE:  w_rd_dat = w_force_rd;
        CSR_STATUS: w_rd_dat = w_rel_rd;
        default:    w_rd_dat = 8'h00;
      endcase
    end
  end

  assign bus.csr_do = w_rd_dat;
  assign bus.out    = ~r_released | r_force;
  assign bus.busy   = (r_state == ST_WAIT);
  assign bus.done   = r_done;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: NUM_RESETS=3, DFL_DELAY=2, one ce every 4 clocks.
// Latency: n/a.
// Backpressure: n/a.
module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam logic [4:0] BASE = 5'h10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rst_seq_if #(.NUM_RESETS(3)) bus ();

  rst_seq #(
    .BASE_ADDR (BASE),
    .NUM_RESETS(3),
    .DFL_DELAY (8'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass   = 0;
  int n_fail   = 0;
  int n_tot    = 0;
  int done_cnt = 0;
  logic       last_done;
  logic [2:0] last_out;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ce_tick();
    bus.ce = 1'b1;
    @(negedge clk);
    bus.ce = 1'b0;
    last_done = bus.done;
    last_out  = bus.out;
    repeat (3) @(negedge clk);
  endtask

  task automatic csr_wr(input logic [1:0] off, input logic [7:0] d);
    bus.csr_a  = BASE + 5'(off);
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    @(negedge clk);
    bus.csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [4:0] a, input string tag, input logic [7:0] exp);
    bus.csr_a = a;
    #1;
    chk(tag, bus.csr_do, exp);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.csr_a  = BASE;
    bus.csr_di = 8'h00;
    bus.csr_we = 1'b0;
    bus.start  = 1'b0;
    bus.ce     = 1'b0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out",  8'(bus.out), 8'h07);
    chk("rst_busy", 8'(bus.busy), 8'h00);
    chk("rst_done", 8'(bus.done), 8'h00);
    rst = 1'b0;
    csr_rd(BASE + 5'd0, "rst_ctrl",   8'h00);
    csr_rd(BASE + 5'd1, "rst_delay",  8'h02);
    csr_rd(BASE + 5'd2, "rst_force",  8'h00);
    csr_rd(BASE + 5'd3, "rst_status", 8'h00);

    // Default delay 2: releases after ticks 3, 6, 9
    pulse_start();
    chk("s1_busy", 8'(bus.busy), 8'h01);
    chk("s1_out0", 8'(bus.out), 8'h07);
    ce_tick(); ce_tick();
    chk("s1_t2_out", 8'(bus.out), 8'h07);
    ce_tick();
    chk("s1_t3_out", 8'(bus.out), 8'h06);
    ce_tick(); ce_tick();
    chk("s1_t5_out", 8'(bus.out), 8'h06);
    ce_tick();
    chk("s1_t6_out", 8'(bus.out), 8'h04);
    ce_tick(); ce_tick();
    chk("s1_t8_donecnt", 8'(done_cnt), 8'h00);
    ce_tick();
    chk("s1_t9_out",     8'(last_out), 8'h00);
    chk("s1_t9_done",    8'(last_done), 8'h01);
    chk("s1_donecnt",    8'(done_cnt), 8'h01);
    chk("s1_busy_end",   8'(bus.busy), 8'h00);
    csr_rd(BASE + 5'd0, "s1_ctrl", 8'h02);

    // Delay 0 via CTRL.START: one line per tick
    csr_wr(CSR_DELAY, 8'h00);
    csr_wr(CSR_CTRL, 8'h01);
    csr_rd(BASE + 5'd0, "s2_ctrl_busy", 8'h01);
    ce_tick();
    csr_rd(BASE + 5'd3, "s2_status1", 8'h01);
    ce_tick();
    csr_rd(BASE + 5'd3, "s2_status2", 8'h03);
    ce_tick();
    csr_rd(BASE + 5'd3, "s2_status3", 8'h07);
    chk("s2_donecnt", 8'(done_cnt), 8'h02);
    csr_rd(BASE + 5'd0, "s2_ctrl_end", 8'h02);

    // FORCE after completion
    csr_wr(CSR_FORCE, 8'h02);
    chk("s3_out_force", 8'(bus.out), 8'h02);
    csr_rd(BASE + 5'd2, "s3_force_rd", 8'h02);
    csr_wr(CSR_FORCE, 8'hFF);
    csr_rd(BASE + 5'd2, "s3_force_unused", 8'h07);
    chk("s3_out_all", 8'(bus.out), 8'h07);
    csr_wr(CSR_FORCE, 8'h00);
    chk("s3_out_clear", 8'(bus.out), 8'h00);
    csr_rd(BASE + 5'd3, "s3_status", 8'h07);
    chk("s3_busy", 8'(bus.busy), 8'h00);

    // ABORT + START together mid-sequence
    csr_wr(CSR_DELAY, 8'h02);
    pulse_start();
    ce_tick();
    csr_wr(CSR_CTRL, 8'h03);
    csr_rd(BASE + 5'd0, "s4_ctrl", 8'h00);
    chk("s4_out",  8'(bus.out), 8'h07);
    chk("s4_busy", 8'(bus.busy), 8'h00);
    csr_rd(BASE + 5'd3, "s4_status", 8'h00);
    repeat (4) ce_tick();
    chk("s4_out_idle", 8'(bus.out), 8'h07);
    chk("s4_donecnt",  8'(done_cnt), 8'h02);

    // START during WAIT ignored; DELAY write applies at next reload
    pulse_start();
    ce_tick(); ce_tick();
    pulse_start();
    ce_tick();
    chk("s5_ign_start", 8'(bus.out), 8'h06);
    csr_wr(CSR_DELAY, 8'h00);
    ce_tick();
    chk("s5_old_cnt1", 8'(bus.out), 8'h06);
    ce_tick();
    chk("s5_old_cnt2", 8'(bus.out), 8'h06);
    ce_tick();
    chk("s5_line1", 8'(bus.out), 8'h04);
    ce_tick();
    chk("s5_line2",   8'(last_out), 8'h00);
    chk("s5_done",    8'(last_done), 8'h01);
    chk("s5_donecnt", 8'(done_cnt), 8'h03);

    // rst mid-sequence after line 0 released
    pulse_start();
    ce_tick();
    chk("s6_line0", 8'(bus.out), 8'h06);
    csr_wr(CSR_FORCE, 8'h01);
    chk("s6_forced", 8'(bus.out), 8'h07);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s6_out",  8'(bus.out), 8'h07);
    chk("s6_busy", 8'(bus.busy), 8'h00);
    chk("s6_done", 8'(bus.done), 8'h00);
    csr_rd(BASE + 5'd1, "s6_delay",  8'h02);
    csr_rd(BASE + 5'd2, "s6_force",  8'h00);
    csr_rd(BASE + 5'd0, "s6_ctrl",   8'h00);
    csr_rd(BASE + 5'd3, "s6_status", 8'h00);
    csr_rd(BASE + 5'd4, "s6_above",  8'h00);
    csr_rd(BASE - 5'd1, "s6_below",  8'h00);
    ce_tick(); ce_tick();
    chk("s6_no_autostart", 8'(bus.out), 8'h07);
    chk("s6_donecnt",      8'(done_cnt), 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
